// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: fetches a missing cache block, writing back a dirty victim first
module cache_refill_ctrl #(
   parameter int BLOCK_WORDS = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             miss_valid,
   output logic                             miss_ready,
   input  logic [31:0]                      miss_addr,
   input  logic                             victim_dirty,
   input  logic [31:0]                      victim_addr,
   input  logic [32*BLOCK_WORDS-1:0]        victim_data,
   output logic                             refill_we,
   output logic [$clog2(BLOCK_WORDS)-1:0]   refill_idx,
   output logic [31:0]                      refill_data,
   output logic                             refill_done,
   output logic                             busy,
   output logic                             mem_req,
   output logic                             mem_we,
   output logic [31:0]                      mem_addr,
   output logic [31:0]                      mem_wdata,
   input  logic                             mem_ack,
   input  logic [31:0]                      mem_rdata
);
   localparam int IW = $clog2(BLOCK_WORDS);
   localparam logic [2:0] IDLE = 3'd0, WB = 3'd1, RD = 3'd2, FILL = 3'd3, DONE = 3'd4;
   localparam logic [IW-1:0] LAST = IW'(BLOCK_WORDS - 1);
   logic [2:0]                state;
   logic [IW-1:0]             cnt, nxt;
   logic [29-IW:0]            miss_tag, vic_tag;
   logic [32*BLOCK_WORDS-1:0] vic_data;
   logic                      last, rd_ack;
   assign nxt         = cnt + IW'(1);
   assign last        = cnt == LAST;
   assign rd_ack      = state == RD && mem_ack;
   assign miss_ready  = state == IDLE;
   assign busy        = state != IDLE;
   assign refill_done = state == DONE;
   // Sequence the writeback and read bursts; every memory-side output is a register held until its ack
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         miss_tag  <= '0;
         vic_tag   <= '0;
         vic_data  <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: if (miss_valid) begin
               miss_tag  <= miss_addr[31:IW+2];
               vic_tag   <= victim_addr[31:IW+2];
               vic_data  <= victim_data;
               cnt       <= '0;
               mem_req   <= 1'b1;
               mem_we    <= victim_dirty;
               mem_addr  <= victim_dirty ? {victim_addr[31:IW+2], (IW+2)'(0)} : {miss_addr[31:IW+2], (IW+2)'(0)};
               mem_wdata <= victim_data[31:0];
               state     <= victim_dirty ? WB : RD;
            end
            WB: if (mem_ack) begin
               cnt       <= last ? '0 : nxt;
               mem_we    <= !last;
               mem_addr  <= last ? {miss_tag, (IW+2)'(0)} : {vic_tag, nxt, 2'b00};
               mem_wdata <= vic_data[{nxt, 5'd0} +: 32];
               state     <= last ? RD : WB;
            end
            RD: if (mem_ack) begin
               cnt      <= nxt;
               mem_req  <= !last;
               mem_addr <= last ? mem_addr : {miss_tag, nxt, 2'b00};
               state    <= last ? FILL : RD;
            end
            FILL:    state <= DONE;
            default: state <= IDLE;
         endcase
      end
   // Each read ack becomes exactly one cache-line write strobe in the following cycle
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         refill_we   <= 1'b0;
         refill_idx  <= '0;
         refill_data <= '0;
      end else begin
         refill_we <= rd_ack;
         if (rd_ack) begin
            refill_idx  <= cnt;
            refill_data <= mem_rdata;
         end
      end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: randomized scoreboard bench for the block refill controller
module tb_cache_refill_ctrl;
   localparam int BW = 8;
   logic            clk = 0, reset = 0, miss_valid = 0, victim_dirty = 0, mem_ack = 0;
   logic [31:0]     miss_addr = 0, victim_addr = 0, mem_rdata = 0;
   logic [32*BW-1:0] victim_data = '0;
   logic            miss_ready, refill_we, refill_done, busy, mem_req, mem_we;
   logic [2:0]      refill_idx;
   logic [31:0]     refill_data, mem_addr, mem_wdata;
   int              checks = 0, failures = 0, cyc = 0, wt = 0, ack_total = 0, wcnt = 0;
   bit              spur = 0, in_txn = 0;
   typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} mem_t;
   typedef struct packed {logic [2:0] idx; logic [31:0] data;} fill_t;
   mem_t  mem_q[$];
   fill_t fill_q[$];
   int    acc_q[$], lat_q[$];
   mem_t  h, e;
   fill_t f;

   cache_refill_ctrl #(.BLOCK_WORDS(BW)) dut (
      .clk(clk), .reset(reset), .miss_valid(miss_valid), .miss_ready(miss_ready),
      .miss_addr(miss_addr), .victim_dirty(victim_dirty), .victim_addr(victim_addr),
      .victim_data(victim_data), .refill_we(refill_we), .refill_idx(refill_idx),
      .refill_data(refill_data), .refill_done(refill_done), .busy(busy),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic miss_event(string name, logic [31:0] info);
      checks++;
      failures++;
      $display("FAIL %s: unexpected event, value %h expected none (cycle %0d)", name, info, cyc);
   endtask

   // Memory contents are a fixed hash of the word address
   function automatic logic [31:0] mdata(logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h1234_5678;
   endfunction

   function automatic logic [32*BW-1:0] rnd_blk();
      logic [32*BW-1:0] v;
      for (int k = 0; k < BW; k++) v[32*k +: 32] = $urandom;
      return v;
   endfunction

   // Memory responder: acks after wt wait cycles, checks hold-stability and scoreboards each transaction
   always @(negedge clk) begin
      mem_ack = 0;
      if (!reset) in_txn = 0;
      else if (mem_req) begin
         if (in_txn) begin
            chk("mem_addr stable", mem_addr, h.addr);
            chk("mem_we stable", 32'(mem_we), 32'(h.we));
            if (h.we) chk("mem_wdata stable", mem_wdata, h.wdata);
         end else begin
            in_txn = 1;
            wcnt = 0;
            h = '{mem_we, mem_addr, mem_wdata};
         end
         if (wcnt == wt) begin
            if (mem_q.size() == 0) miss_event("mem txn", mem_addr);
            else begin
               e = mem_q.pop_front();
               chk("mem_we", 32'(mem_we), 32'(e.we));
               chk("mem_addr", mem_addr, e.addr);
               if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
            end
            mem_ack = 1;
            mem_rdata = mem_we ? $urandom : mdata(mem_addr);
            in_txn = 0;
            ack_total++;
         end else wcnt++;
      end else begin
         in_txn = 0;
         if (spur) begin
            mem_ack = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
         end
      end
   end

   // Refill monitor: scoreboards line writes and completion latency
   always @(negedge clk) begin
      if (reset) begin
         chk("miss_ready vs busy", 32'(miss_ready), 32'(!busy));
         if (refill_we) begin
            if (fill_q.size() == 0) miss_event("refill_we", refill_data);
            else begin
               f = fill_q.pop_front();
               chk("refill_idx", 32'(refill_idx), 32'(f.idx));
               chk("refill_data", refill_data, f.data);
            end
         end
         if (refill_done) begin
            chk("miss_ready in done", 32'(miss_ready), 32'(0));
            if (acc_q.size() == 0) miss_event("refill_done", 32'(cyc));
            else chk("done latency", 32'(cyc - acc_q.pop_front()), 32'(lat_q.pop_front()));
         end
      end
   end

   task automatic issue(logic [31:0] ma, logic [31:0] va, logic [32*BW-1:0] vd, logic dirty, int w, bit hold);
      int n = 0;
      mem_t m;
      fill_t fl;
      @(negedge clk);
      miss_addr = ma; victim_addr = va; victim_data = vd; victim_dirty = dirty;
      miss_valid = 1; wt = w;
      while (!miss_ready && n < 2000) begin @(negedge clk); n++; end
      if (!miss_ready) begin
         miss_event("accept timeout", ma);
         miss_valid = 0;
         return;
      end
      for (int k = 0; dirty && k < BW; k++) begin
         m = '{1'b1, (va & ~32'h1f) + 32'(4*k), vd[32*k +: 32]};
         mem_q.push_back(m);
      end
      for (int k = 0; k < BW; k++) begin
         m = '{1'b0, (ma & ~32'h1f) + 32'(4*k), 32'h0};
         mem_q.push_back(m);
         fl = '{k[2:0], mdata((ma & ~32'h1f) + 32'(4*k))};
         fill_q.push_back(fl);
      end
      acc_q.push_back(cyc);
      lat_q.push_back((dirty ? 2*BW : BW) * (w + 1) + 2);
      @(negedge clk);
      if (!hold) miss_valid = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((mem_q.size() != 0 || fill_q.size() != 0 || acc_q.size() != 0 || busy) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) miss_event("idle timeout", 32'(mem_q.size()));
   endtask

   task automatic reset_vals(string tag);
      chk({tag, " mem_req"}, 32'(mem_req), 0);
      chk({tag, " mem_we"}, 32'(mem_we), 0);
      chk({tag, " refill_we"}, 32'(refill_we), 0);
      chk({tag, " refill_done"}, 32'(refill_done), 0);
      chk({tag, " busy"}, 32'(busy), 0);
      chk({tag, " miss_ready"}, 32'(miss_ready), 1);
      chk({tag, " refill_idx"}, 32'(refill_idx), 0);
      chk({tag, " mem_addr"}, mem_addr, 0);
      chk({tag, " mem_wdata"}, mem_wdata, 0);
      chk({tag, " refill_data"}, refill_data, 0);
   endtask

   // Directed scenarios first, then a randomized mix
   initial begin
      logic [32*BW-1:0] vd;
      int base, n;
      #1 reset_vals("por");
      repeat (2) @(negedge clk);
      reset = 1;
      issue(32'h0000_1234, $urandom, rnd_blk(), 0, 0, 0);
      wait_idle();
      for (int k = 0; k < BW; k++) vd[32*k +: 32] = 32'hA0 + 32'(k);
      issue(32'h0000_0100, 32'h0000_8040, vd, 1, 0, 0);
      wait_idle();
      issue($urandom, $urandom, rnd_blk(), 1, 3, 0);
      wait_idle();
      issue($urandom, $urandom, rnd_blk(), 0, 3, 0);
      wait_idle();
      spur = 1;
      issue($urandom, $urandom, rnd_blk(), 1'($urandom), 1, 1);
      issue($urandom, $urandom, rnd_blk(), 1'($urandom), 1, 0);
      wait_idle();
      spur = 0;
      base = ack_total;
      n = 0;
      issue(32'h0000_4460, $urandom, rnd_blk(), 0, 0, 0);
      while (ack_total < base + 3 && n < 200) begin @(posedge clk); n++; end
      #2 reset = 0;
      #1 reset_vals("async rst");
      mem_q.delete(); fill_q.delete(); acc_q.delete(); lat_q.delete();
      repeat (3) begin
         @(negedge clk);
         chk("rst refill_we", 32'(refill_we), 0);
         chk("rst refill_done", 32'(refill_done), 0);
      end
      reset = 1;
      issue(32'h0000_4460, $urandom, rnd_blk(), 0, 0, 0);
      wait_idle();
      for (int i = 0; i < 3; i++) issue($urandom, $urandom, rnd_blk(), 1'($urandom), 0, 1);
      issue($urandom, $urandom, rnd_blk(), 1'($urandom), 0, 0);
      wait_idle();
      for (int i = 0; i < 10; i++) begin
         spur = 1'($urandom);
         issue($urandom, $urandom, rnd_blk(), 1'($urandom), $urandom_range(0, 2), 0);
         wait_idle();
      end
      spur = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
